// File: rtl/waterfall_writer.sv
// -----------------------------------------------------------------------------
// waterfall_writer
//
// Takes a streamed FFT magnitude frame, keeps the positive-frequency half
// (bins 0..BINS-1), compresses each bin to a DATA_WIDTH log-scale intensity
// and writes it as one row of the banked circular waterfall RAM. After reset
// or clear_req the whole waterfall is swept to zero before frames are taken.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   s_mag/s_valid/   magnitude stream, bin order 0..FFT_SIZE-1,
//   s_last/s_ready   s_last marks bin FFT_SIZE-1
//   clear_req        one-cycle pulse, restart the zero sweep
//   wr_bank_en       one-hot bank write strobe (all zero = idle)
//   wr_addr/wr_data  address within bank, intensity
//   oldest_fft_idx   row that will be overwritten next
//   busy             zero sweep in progress
//   frame_err        one-cycle pulse, malformed frame discarded
//
// state | meaning
// ------+------------------------------------------------------------
// CLEAR | zero sweep, one RAM word per cycle, stream held off
// RUN   | accepting frame samples, bins < BINS are written
// DROP  | frame overran without s_last, consume until s_last
// -----------------------------------------------------------------------------
module waterfall_writer #(
    parameter int FFT_SIZE       = 256,
    parameter int DATA_WIDTH     = 4,
    parameter int MAG_WIDTH      = 32,
    parameter int NO_FFTS        = 50,
    parameter int NO_BANKS       = 2,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int LOG_OFFSET     = 8,
    parameter int IDX_WIDTH      = $clog2(NO_FFTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MAG_WIDTH-1:0]      s_mag,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    input  logic                      clear_req,
    output logic [NO_BANKS-1:0]       wr_bank_en,
    output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [IDX_WIDTH-1:0]      oldest_fft_idx,
    output logic                      busy,
    output logic                      frame_err
);

    localparam int BINS          = FFT_SIZE / 2;
    localparam int ROWS_PER_BANK = (2 ** RAM_ADDR_WIDTH) / BINS;
    localparam int KW            = $clog2(FFT_SIZE);
    localparam int LW            = $clog2(NO_FFTS * BINS);
    localparam int QMAX          = (2 ** DATA_WIDTH) - 1;

    localparam logic [KW-1:0]        K_LAST     = KW'(FFT_SIZE - 1);
    localparam logic [KW-1:0]        K_BINS     = KW'(BINS);
    localparam logic [IDX_WIDTH-1:0] ROW_LAST   = IDX_WIDTH'(NO_FFTS - 1);
    localparam logic [LW-1:0]        SWEEP_LAST = LW'(NO_FFTS * BINS - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DROP  = 2'd2
    } state_t;

    // Row/bin to {one-hot bank, address within bank}.
    function automatic logic [NO_BANKS+RAM_ADDR_WIDTH-1:0] map_rb(input int r, input int b);
        logic [NO_BANKS-1:0]       bank;
        logic [RAM_ADDR_WIDTH-1:0] addr;
        for (int i = 0; i < NO_BANKS; i++) begin
            bank[i] = ((r / ROWS_PER_BANK) == i);
        end
        addr = RAM_ADDR_WIDTH'((r % ROWS_PER_BANK) * BINS + b);
        return {bank, addr};
    endfunction

    // MSB position minus LOG_OFFSET, saturated to the intensity range.
    function automatic logic [DATA_WIDTH-1:0] quant(input logic [MAG_WIDTH-1:0] mag);
        int m;
        m = -1;
        for (int i = 0; i < MAG_WIDTH; i++) begin
            if (mag[i]) m = i;
        end
        if (m < LOG_OFFSET) return '0;
        if ((m - LOG_OFFSET + 1) > QMAX) return DATA_WIDTH'(QMAX);
        return DATA_WIDTH'(m - LOG_OFFSET + 1);
    endfunction

    state_t                    state_q, state_d;
    logic [LW-1:0]             sweep_q, sweep_d;
    logic [KW-1:0]             k_q, k_d;
    logic [IDX_WIDTH-1:0]      row_q, row_d;
    logic                      s_ready_q, s_ready_d;
    logic                      busy_q, busy_d;

    // stage 1: encoded sample
    logic                      s1_we_q, s1_we_d;
    logic [NO_BANKS-1:0]       s1_bank_q, s1_bank_d;
    logic [RAM_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0]     s1_data_q, s1_data_d;
    logic                      s1_commit_q, s1_commit_d;
    logic [IDX_WIDTH-1:0]      s1_row_q, s1_row_d;
    logic                      s1_err_q, s1_err_d;

    // stage 2: outputs
    logic [NO_BANKS-1:0]       wr_bank_q, wr_bank_d;
    logic [RAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [IDX_WIDTH-1:0]      oldest_q, oldest_d;
    logic                      frame_err_q, frame_err_d;

    logic                      accept;
    logic [IDX_WIDTH-1:0]      row_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            sweep_q     <= '0;
            k_q         <= '0;
            row_q       <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b1;
            s1_we_q     <= 1'b0;
            s1_bank_q   <= '0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_commit_q <= 1'b0;
            s1_row_q    <= '0;
            s1_err_q    <= 1'b0;
            wr_bank_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            oldest_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            k_q         <= k_d;
            row_q       <= row_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            s1_we_q     <= s1_we_d;
            s1_bank_q   <= s1_bank_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            s1_commit_q <= s1_commit_d;
            s1_row_q    <= s1_row_d;
            s1_err_q    <= s1_err_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            oldest_q    <= oldest_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        accept   = s_valid & s_ready_q;
        row_next = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

        state_d     = state_q;
        sweep_d     = sweep_q;
        k_d         = k_q;
        row_d       = row_q;
        // s_ready/busy are registered views of the state, so they lag by one
        // cycle on entry to RUN and on clear_req.
        s_ready_d   = (state_q != CLEAR) && !clear_req;
        busy_d      = !s_ready_d;

        s1_we_d     = 1'b0;
        s1_bank_d   = s1_bank_q;
        s1_addr_d   = s1_addr_q;
        s1_data_d   = s1_data_q;
        s1_commit_d = 1'b0;
        s1_row_d    = s1_row_q;
        s1_err_d    = 1'b0;

        wr_bank_d   = s1_we_q ? s1_bank_q : '0;
        wr_addr_d   = s1_addr_q;
        wr_data_d   = s1_data_q;
        oldest_d    = s1_commit_q ? s1_row_q : oldest_q;
        frame_err_d = s1_err_q;

        unique case (state_q)
            CLEAR: begin
                {wr_bank_d, wr_addr_d} = map_rb(int'(sweep_q) / BINS, int'(sweep_q) % BINS);
                wr_data_d = '0;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = RUN;
                    sweep_d = '0;
                    row_d   = '0;
                    k_d     = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end

            RUN, DROP: begin
                if (clear_req) begin
                    // Drop whatever is in flight; the sweep owns the RAM port next.
                    state_d     = CLEAR;
                    sweep_d     = '0;
                    row_d       = '0;
                    k_d         = '0;
                    oldest_d    = '0;
                    wr_bank_d   = '0;
                    frame_err_d = 1'b0;
                end else if (accept && (state_q == RUN)) begin
                    s1_we_d                = (k_q < K_BINS);
                    {s1_bank_d, s1_addr_d} = map_rb(int'(row_q), int'(k_q));
                    s1_data_d              = quant(s_mag);
                    if (s_last) begin
                        k_d = '0;
                        if (k_q == K_LAST) begin
                            s1_commit_d = 1'b1;
                            s1_row_d    = row_next;
                            row_d       = row_next;
                        end else begin
                            s1_err_d = 1'b1;
                        end
                    end else if (k_q == K_LAST) begin
                        s1_err_d = 1'b1;
                        k_d      = '0;
                        state_d  = DROP;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (accept && s_last) begin
                    state_d = RUN;
                    k_d     = '0;
                end
            end

            default: begin
                state_d = CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    assign s_ready        = s_ready_q;
    assign busy           = busy_q;
    assign wr_bank_en     = wr_bank_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign oldest_fft_idx = oldest_q;
    assign frame_err      = frame_err_q;

endmodule

// File: doc/waterfall_writer.md
# waterfall_writer

Upstream stage of the spectrogram display path. Consumes a streamed FFT magnitude frame, keeps the positive-frequency half, and compresses each bin to a DATA_WIDTH log-scale intensity. Writes the result into the banked waterfall RAM as one row per FFT, and maintains the circular row pointer that the display side reads as OLDEST_FFT_IDX. On reset or on request, it first sweeps the whole waterfall to zero so the screen starts blank.

## Interface
Parameters:
- FFT_SIZE, 256, samples per input frame; BINS = FFT_SIZE/2 written per row
- DATA_WIDTH, 4, stored intensity width
- MAG_WIDTH, 32, input magnitude width (unsigned)
- NO_FFTS, 50, rows in the circular waterfall; IDX_WIDTH = $clog2(NO_FFTS)
- NO_BANKS, 2, RAM banks
- RAM_ADDR_WIDTH, 12, per-bank address width; ROWS_PER_BANK = 2^RAM_ADDR_WIDTH / BINS (32); NO_FFTS <= NO_BANKS*ROWS_PER_BANK
- LOG_OFFSET, 8, MSB position mapped to intensity 1

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- s_mag  in  MAG_WIDTH  bin magnitude, bin order 0..FFT_SIZE-1
- s_valid  in  1  s_mag valid
- s_last  in  1  marks bin FFT_SIZE-1
- s_ready  out  1  accept; transfer when s_valid & s_ready
- clear_req  in  1  one-cycle pulse: restart zero sweep
- wr_bank_en  out  NO_BANKS  one-hot write strobe, all-zero = no write
- wr_addr  out  RAM_ADDR_WIDTH  write address within bank
- wr_data  out  DATA_WIDTH  intensity
- oldest_fft_idx  out  IDX_WIDTH  row next to be overwritten (feeds OLDEST_FFT_IDX)
- busy  out  1  clear sweep in progress
- frame_err  out  1  one-cycle pulse, malformed frame discarded

## Operation
- States: CLEAR, RUN, DROP. Reset enters CLEAR.
- Reset values: state CLEAR, sweep counter 0, bin 0, row 0, oldest_fft_idx 0, s_ready 0, busy 1, wr_bank_en 0, wr_addr 0, wr_data 0, frame_err 0.
- CLEAR: linear index L counts 0..NO_FFTS*BINS-1, one write of 0 per cycle; row = L/BINS, bin = L%BINS mapped as below. s_ready 0, busy 1. After L = NO_FFTS*BINS-1 is written, go to RUN with row 0, bin 0, oldest 0, busy 0. clear_req in CLEAR is ignored.
- Address map for (row r, bin b): bank = r / ROWS_PER_BANK (one-hot on wr_bank_en), wr_addr = (r % ROWS_PER_BANK)*BINS + b.
- RUN: s_ready 1. Each accepted sample increments bin counter k (0..FFT_SIZE-1).
  - Only bins with k < BINS produce a write. Bins k >= BINS are consumed silently.
- Quantisation: m = MSB index of s_mag. wr_data = 0 if s_mag == 0 or m < LOG_OFFSET; otherwise min(2^DATA_WIDTH-1, m-LOG_OFFSET+1).
- Commit: s_last accepted with k == FFT_SIZE-1 advances the row: row <= (row+1) mod NO_FFTS, oldest_fft_idx <= new row, k <= 0.
- Early s_last (k < FFT_SIZE-1): pulse frame_err, no commit, k <= 0. The same row is rewritten by the next frame; partial writes already issued stay.
- k == FFT_SIZE-1 accepted without s_last: pulse frame_err, no commit, go to DROP.
- DROP: s_ready 1, samples consumed, no writes. The sample with s_last accepted returns the block to RUN with k = 0.
- clear_req in RUN/DROP: next cycle enter CLEAR with L = 0, row 0, oldest 0. In-flight pipeline writes are cancelled (wr_bank_en forced 0). clear_req has priority over a same-cycle accept.

## Timing
- Two-stage pipeline: sample accepted at cycle T → registered at T+1 (MSB encode) → wr_* valid for one cycle at T+2.
- oldest_fft_idx updates at T+2 for the committing s_last accepted at T. frame_err pulses at T+2 for the offending accept.
- Gaps in s_valid: wr_bank_en 0 in the corresponding cycles; no bubbles are inserted otherwise. Full rate is one sample per cycle.
- s_ready is registered: it rises the cycle after CLEAR ends and falls the cycle after clear_req.
- The clear sweep writes at L appear at cycle start+L+1 (one register stage). The sweep lasts NO_FFTS*BINS = 6400 cycles.
- rst_n assertion mid-operation: all outputs take their reset values immediately (asynchronously).

## Test plan
- Reset release → 6400 zero writes, first bank 01 addr 0, last bank 10 addr 2303 (row 49). busy falls, and s_ready goes 1 the cycle after the last write.
- One frame at row 0 with bin k magnitude = 1<<(k%32) → bin 7 writes 0, bin 8 writes 1, bin 22 writes 15, bin 31 writes 15. Writes land on bank 01, addr k, at T+2. Bins 128..255 produce no writes. oldest_fft_idx becomes 1.
- 32 clean frames then one more → frame 33 writes bank 10 addr 0..127. After 50 frames oldest_fft_idx wraps to 0.
- s_last on bin 100 → frame_err pulse, oldest unchanged. The next clean frame rewrites the same row and then commits.
- 300 samples without s_last, then s_last → frame_err at bin 255+2 cycles, no writes for bins 256..299, no commit. The following frame is accepted normally.
- clear_req at bin 50 with random s_valid gaps → the two pipelined writes are suppressed, a full 6400-cycle sweep runs, oldest 0, and the next frame writes row 0.
